wireframe_line_draw: RTL and testbench



---
 rtl/wireframe_line_draw_if.sv | 45 ++++
 rtl/wireframe_line_draw.sv | 151 +++++++++++++++
 tb/tb_wireframe_line_draw.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wireframe_line_draw_if.sv
// Handshake bundle between the line-draw requester, the rasterizer and the plot stage.
// Points are packed {x, y} so they can be compared and copied as one vector.
interface wireframe_line_draw_if #(
  parameter int unsigned COORD_W = 10
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  logic   start;
  point_t p0;
  point_t p1;
  logic   hold;
  logic   busy;
  logic   done;
  logic   plot;
  point_t plot_point;

  // Requester / plot-stage side
  modport master (
    output start,
    output p0,
    output p1,
    output hold,
    input  busy,
    input  done,
    input  plot,
    input  plot_point
  );

  // Rasterizer side
  modport slave (
    input  start,
    input  p0,
    input  p1,
    input  hold,
    output busy,
    output done,
    output plot,
    output plot_point
  );

endinterface

// File: rtl/wireframe_line_draw.sv
// Integer Bresenham line rasterizer: walks one pixel per clock from p0 to p1 and issues
// plot requests for on-screen pixels. Off-screen pixels are stepped through silently.
module wireframe_line_draw #(
  parameter int unsigned WIDTH   = 640,
  parameter int unsigned HEIGHT  = 480,
  parameter int unsigned COORD_W = 10
) (
  input logic                  clk,
  input logic                  n_rst,
  wireframe_line_draw_if.slave bus
);

  // Error term width; 2*err needs one extra bit on top of this.
  localparam int unsigned EW = COORD_W + 2;

  localparam logic [COORD_W:0] XLim = (COORD_W + 1)'(WIDTH);
  localparam logic [COORD_W:0] YLim = (COORD_W + 1)'(HEIGHT);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StDraw,
    StDone
  } state_e;

  state_e r_state, w_state_d;
  point_t r_cur, w_cur_d;
  point_t r_end, w_end_d;

  logic signed [EW-1:0] r_dx, w_dx_d;
  logic signed [EW-1:0] r_dy, w_dy_d;
  logic signed [EW-1:0] r_err, w_err_d;
  logic                 r_sx_neg, w_sx_neg_d;
  logic                 r_sy_neg, w_sy_neg_d;

  logic signed [EW-1:0] w_diff_x;
  logic signed [EW-1:0] w_diff_y;
  logic signed [EW:0]   w_e2;
  logic signed [EW:0]   w_dx_ext;
  logic signed [EW:0]   w_dy_ext;
  logic                 w_step_x;
  logic                 w_step_y;
  logic                 w_on_screen;

  // Endpoint deltas and Bresenham decision terms
  always_comb begin
    w_diff_x    = $signed({2'b00, r_end.x}) - $signed({2'b00, r_cur.x});
    w_diff_y    = $signed({2'b00, r_end.y}) - $signed({2'b00, r_cur.y});
    w_e2        = {r_err, 1'b0};
    w_dx_ext    = r_dx;
    w_dy_ext    = r_dy;
    w_step_x    = (w_e2 >= w_dy_ext);
    w_step_y    = (w_e2 <= w_dx_ext);
    w_on_screen = ({1'b0, r_cur.x} < XLim) && ({1'b0, r_cur.y} < YLim);
  end

  // Next-state and datapath update
  always_comb begin
    w_state_d  = r_state;
    w_cur_d    = r_cur;
    w_end_d    = r_end;
    w_dx_d     = r_dx;
    w_dy_d     = r_dy;
    w_err_d    = r_err;
    w_sx_neg_d = r_sx_neg;
    w_sy_neg_d = r_sy_neg;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_cur_d   = bus.p0;
          w_end_d   = bus.p1;
          w_state_d = StInit;
        end
      end

      StInit: begin
        w_sx_neg_d = w_diff_x[EW-1];
        w_sy_neg_d = w_diff_y[EW-1];
        w_dx_d     = w_diff_x[EW-1] ? -w_diff_x : w_diff_x;
        // dy is kept negative so both decision tests share the same form
        w_dy_d     = w_diff_y[EW-1] ? w_diff_y : -w_diff_y;
        w_err_d    = (w_diff_x[EW-1] ? -w_diff_x : w_diff_x)
                   + (w_diff_y[EW-1] ? w_diff_y : -w_diff_y);
        w_state_d  = StDraw;
      end

      StDraw: begin
        if (!bus.hold) begin
          if (r_cur == r_end) begin
            w_state_d = StDone;
          end else begin
            // Both tests use the pre-update error; both steps may apply together
            if (w_step_x) begin
              w_cur_d.x = r_sx_neg ? r_cur.x - COORD_W'(1) : r_cur.x + COORD_W'(1);
            end
            if (w_step_y) begin
              w_cur_d.y = r_sy_neg ? r_cur.y - COORD_W'(1) : r_cur.y + COORD_W'(1);
            end
            w_err_d = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
          end
        end
      end

      StDone: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= StIdle;
      r_cur    <= '0;
      r_end    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cur    <= w_cur_d;
      r_end    <= w_end_d;
      r_dx     <= w_dx_d;
      r_dy     <= w_dy_d;
      r_err    <= w_err_d;
      r_sx_neg <= w_sx_neg_d;
      r_sy_neg <= w_sy_neg_d;
    end
  end

  // Outputs come from registered state; hold only gates the plot strobe
  always_comb begin
    bus.busy       = (r_state != StIdle);
    bus.done       = (r_state == StDone);
    bus.plot       = (r_state == StDraw) && !bus.hold && w_on_screen;
    bus.plot_point = r_cur;
  end

endmodule

// File: tb/tb_wireframe_line_draw.sv
// Directed bench for wireframe_line_draw: hand-computed pixel sequences, latency,
// clipping, hold, mid-line reset and start-while-busy.
module tb_wireframe_line_draw;

  logic clk;
  logic n_rst;

  wireframe_line_draw_if #(.COORD_W(10)) bus_if ();

  wireframe_line_draw #(
    .WIDTH  (640),
    .HEIGHT (480),
    .COORD_W(10)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];
  int          busy_n;
  int          first_plot;
  bit          saw_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pt(input int x, input int y);
    logic [9:0] xs;
    logic [9:0] ys;
    xs = 10'(x);
    ys = 10'(y);
    return {xs, ys};
  endfunction

  function automatic logic [19:0] cur_pt();
    return {bus_if.plot_point.x, bus_if.plot_point.y};
  endfunction

  // Draws one line and records plotted pixels. hold_x >= 0 holds for 3 cycles when that x is
  // presented; rst_x >= 0 pulses reset at that x; poke_cyc > 0 pulses a foreign start then.
  task automatic do_line(input int x0, input int y0, input int x1, input int y1,
                         input int hold_x, input int rst_x, input int poke_cyc);
    bit held;
    bit was_reset;
    held      = 1'b0;
    was_reset = 1'b0;
    got_q.delete();
    busy_n     = 0;
    first_plot = -1;
    saw_done   = 1'b0;
    bus_if.p0.x  = 10'(x0);
    bus_if.p0.y  = 10'(y0);
    bus_if.p1.x  = 10'(x1);
    bus_if.p1.y  = 10'(y1);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (rst_x >= 0 && bus_if.plot && int'(bus_if.plot_point.x) == rst_x) begin
        n_rst = 1'b0;
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_plot", 32'(bus_if.plot), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_point", 32'(cur_pt()), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_idle", 32'(bus_if.busy), 32'd0);
        was_reset = 1'b1;
        break;
      end
      if (hold_x >= 0 && !held && bus_if.plot && int'(bus_if.plot_point.x) == hold_x) begin
        held        = 1'b1;
        bus_if.hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
          #1;
          check("hold_plot", 32'(bus_if.plot), 32'd0);
          check("hold_point", 32'(cur_pt()), 32'(pt(hold_x, 0)));
          @(posedge clk);
          #1;
        end
        bus_if.hold = 1'b0;
        #1;
      end
      if (bus_if.busy) busy_n++;
      if (bus_if.plot) begin
        got_q.push_back(cur_pt());
        if (first_plot < 0) first_plot = cyc;
      end
      if (bus_if.done) begin
        saw_done = 1'b1;
        break;
      end
      if (cyc == poke_cyc) begin
        bus_if.start = 1'b1;
        bus_if.p0.x  = 10'd100;
        bus_if.p0.y  = 10'd100;
        bus_if.p1.x  = 10'd200;
        bus_if.p1.y  = 10'd50;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus_if.start = 1'b0;
    if (!was_reset) begin
      check("done_seen", 32'(saw_done), 32'd1);
      @(posedge clk);
      #1;
      check("idle_busy", 32'(bus_if.busy), 32'd0);
      check("idle_done", 32'(bus_if.done), 32'd0);
    end
  endtask

  task automatic check_pts(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, "_pt"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    n_rst        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.hold  = 1'b0;
    bus_if.p0    = '0;
    bus_if.p1    = '0;
    #12;
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_done", 32'(bus_if.done), 32'd0);
    check("reset_plot", 32'(bus_if.plot), 32'd0);
    check("reset_point", 32'(cur_pt()), 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Horizontal line: latency and busy length
    do_line(0, 0, 3, 0, -1, -1, 0);
    exp_q = '{pt(0, 0), pt(1, 0), pt(2, 0), pt(3, 0)};
    check_pts("horiz");
    check("horiz_first", 32'(first_plot), 32'd2);
    check("horiz_busy", 32'(busy_n), 32'd6);

    // Steep line
    do_line(0, 0, 1, 3, -1, -1, 0);
    exp_q = '{pt(0, 0), pt(0, 1), pt(1, 2), pt(1, 3)};
    check_pts("steep");

    // Reverse diagonal, negative steps
    do_line(5, 5, 2, 2, -1, -1, 0);
    exp_q = '{pt(5, 5), pt(4, 4), pt(3, 3), pt(2, 2)};
    check_pts("revdiag");

    // Degenerate point
    do_line(7, 9, 7, 9, -1, -1, 0);
    exp_q = '{pt(7, 9)};
    check_pts("point");
    check("point_busy", 32'(busy_n), 32'd3);

    // Clipping at right edge: 4 draw cycles, 2 plots
    do_line(638, 0, 641, 0, -1, -1, 0);
    exp_q = '{pt(638, 0), pt(639, 0)};
    check_pts("clip");
    check("clip_busy", 32'(busy_n), 32'd6);

    // Hold for 3 cycles at (4,0)
    do_line(0, 0, 9, 0, 4, -1, 0);
    exp_q = '{pt(0, 0), pt(1, 0), pt(2, 0), pt(3, 0), pt(4, 0),
              pt(5, 0), pt(6, 0), pt(7, 0), pt(8, 0), pt(9, 0)};
    check_pts("hold");
    check("hold_busy", 32'(busy_n), 32'd12);

    // Reset mid-line, then a fresh line
    do_line(0, 0, 9, 0, -1, 6, 0);
    do_line(3, 2, 0, 0, -1, -1, 0);
    exp_q = '{pt(3, 2), pt(2, 1), pt(1, 1), pt(0, 0)};
    check_pts("after_rst");

    // Start during DRAW is ignored
    do_line(0, 0, 4, 2, -1, -1, 3);
    exp_q = '{pt(0, 0), pt(1, 1), pt(2, 1), pt(3, 2), pt(4, 2)};
    check_pts("busy_start");
    check("busy_start_len", 32'(busy_n), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
